// File: rtl/qfmt_alu_pipe_pkg.sv
// qfmt_pkg: shared definitions for the qfmt_alu_pipe fixed-point unit.
//   op_e       : operation select encoding (add, sub, mul, pass A)
//   calc_aw    : internal aligned-operand width for a given W/FA/FB/FO
//   sat_max/min: signed saturation bounds for a W-bit result
//   half_lsb   : rounding bias 2^(s-1) for a right shift by s (0 when s=0)
package qfmt_pkg;

    typedef enum logic [1:0] {
        OP_ADD  = 2'b00,
        OP_SUB  = 2'b01,
        OP_MUL  = 2'b10,
        OP_PASS = 2'b11
    } op_e;

    // Room for the largest left shift plus one guard bit for rounding carry.
    function automatic int calc_aw(input int w, input int fa, input int fb, input int fo);
        int ext;
        ext = 0;
        if (fo - fa > ext) ext = fo - fa;
        if (fo - fb > ext) ext = fo - fb;
        return w + ext + 1;
    endfunction

    function automatic longint sat_max(input int w);
        return (longint'(1) <<< (w - 1)) - longint'(1);
    endfunction

    function automatic longint sat_min(input int w);
        return -(longint'(1) <<< (w - 1));
    endfunction

    function automatic longint half_lsb(input int s);
        return (s > 0) ? (longint'(1) <<< (s - 1)) : longint'(0);
    endfunction

endpackage

// File: rtl/qfmt_alu_pipe_if.sv
// qfmt_alu_pipe_if: operand/result handshake bundle for qfmt_alu_pipe.
//   in_valid/in_ready   : operand beat handshake
//   in_a, in_b, in_op   : operands (W bits each) and op select (2 bits)
//   out_valid/out_ready : result handshake
//   out_res, out_ovf    : saturated result (W bits) and saturation flag
// master = producer/consumer side (testbench), slave = the unit.
interface qfmt_alu_pipe_if #(
    parameter int W = 16
);
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic [1:0]   in_op;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_res;
    logic         out_ovf;

    modport master (
        output in_valid, in_a, in_b, in_op, out_ready,
        input  in_ready, out_valid, out_res, out_ovf
    );

    modport slave (
        input  in_valid, in_a, in_b, in_op, out_ready,
        output in_ready, out_valid, out_res, out_ovf
    );
endinterface

// File: rtl/qfmt_alu_pipe_align.sv
// qfmt_align: combinational re-alignment of a signed Q(W-FI,FI) word to FO
// fraction bits in an AW-bit signed result.
//   din  : W-bit two's complement input
//   dout : AW-bit two's complement output with FO fraction bits
// Left shifts are exact. Right shifts truncate toward -inf, or round to
// nearest with ties toward +inf when QFMT_ROUND_EN is defined.
module qfmt_align
    import qfmt_pkg::*;
#(
    parameter int W  = 16,
    parameter int FI = 14,
    parameter int FO = 13,
    parameter int AW = 18
) (
    input  logic [W-1:0]         din,
    output logic signed [AW-1:0] dout
);
    localparam int SH_L = (FO >= FI) ? FO - FI : 0;
    localparam int SH_R = (FI > FO) ? FI - FO : 0;
`ifdef QFMT_ROUND_EN
    localparam logic signed [AW-1:0] HALF = AW'(half_lsb(SH_R));
`endif

    logic signed [AW-1:0] ext;
    logic signed [AW-1:0] biased;

    always_comb begin
        ext = {{(AW - W){din[W-1]}}, din};
`ifdef QFMT_ROUND_EN
        biased = ext + HALF;
`else
        biased = ext;
`endif
        if (FO >= FI) dout = ext <<< SH_L;
        else          dout = biased >>> SH_R;
    end
endmodule

// File: rtl/qfmt_alu_pipe.sv
// qfmt_alu_pipe: 3-stage fixed-point add/sub/mul/pass unit with saturation.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : qfmt_alu_pipe_if.slave (in_valid/in_ready/in_a/in_b/in_op,
//                out_valid/out_ready/out_res/out_ovf)
// Stages: S1 align both operands to FO fraction bits, S2 compute, S3 saturate.
// Optional macro QFMT_ROUND_EN: round-to-nearest (ties to +inf) on every
// right shift instead of truncation.
module qfmt_alu_pipe
    import qfmt_pkg::*;
#(
    parameter int W  = 16,
    parameter int FA = 14,
    parameter int FB = 12,
    parameter int FO = 13
) (
    input  logic            clk,
    input  logic            rst_n,
    qfmt_alu_pipe_if.slave  bus
);
    localparam int AW = calc_aw(W, FA, FB, FO);
    localparam int RW = 2 * AW;
    localparam logic signed [RW-1:0] SMAX = RW'(sat_max(W));
    localparam logic signed [RW-1:0] SMIN = RW'(sat_min(W));
`ifdef QFMT_ROUND_EN
    localparam logic signed [RW-1:0] MHALF = RW'(half_lsb(FO));
`endif

    logic                 v1, v2, v3;
    logic                 rdy1, rdy2, rdy3;
    logic signed [AW-1:0] a_al, b_al;
    logic signed [AW-1:0] a1, b1;
    op_e                  op1;
    logic signed [AW:0]   sum;
    logic signed [RW-1:0] prod, prod_adj, alu, res2;
    logic [W-1:0]         res3;
    logic                 ovf3;

    qfmt_align #(.W(W), .FI(FA), .FO(FO), .AW(AW)) u_align_a (
        .din  (bus.in_a),
        .dout (a_al)
    );

    qfmt_align #(.W(W), .FI(FB), .FO(FO), .AW(AW)) u_align_b (
        .din  (bus.in_b),
        .dout (b_al)
    );

    // Backpressure ripples combinationally from out_ready up to in_ready.
    assign rdy3 = !v3 || bus.out_ready;
    assign rdy2 = !v2 || rdy3;
    assign rdy1 = !v1 || rdy2;

    assign bus.in_ready  = rdy1;
    assign bus.out_valid = v3;
    assign bus.out_res   = res3;
    assign bus.out_ovf   = ovf3;

    always_comb begin
        sum  = '0;
        alu  = '0;
        prod = RW'(a1) * RW'(b1);
`ifdef QFMT_ROUND_EN
        prod_adj = (prod + MHALF) >>> FO;
`else
        prod_adj = prod >>> FO;
`endif
        case (op1)
            OP_ADD: begin
                sum = (AW + 1)'(a1) + (AW + 1)'(b1);
                alu = RW'(sum);
            end
            OP_SUB: begin
                sum = (AW + 1)'(a1) - (AW + 1)'(b1);
                alu = RW'(sum);
            end
            OP_MUL:  alu = prod_adj;
            OP_PASS: alu = RW'(a1);
            default: alu = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1   <= 1'b0;
            v2   <= 1'b0;
            v3   <= 1'b0;
            a1   <= '0;
            b1   <= '0;
            op1  <= OP_ADD;
            res2 <= '0;
            res3 <= '0;
            ovf3 <= 1'b0;
        end else begin
            if (rdy1) begin
                v1 <= bus.in_valid;
                if (bus.in_valid) begin
                    a1  <= a_al;
                    b1  <= b_al;
                    op1 <= op_e'(bus.in_op);
                end
            end
            if (rdy2) begin
                v2 <= v1;
                if (v1) res2 <= alu;
            end
            if (rdy3) begin
                v3 <= v2;
                if (v2) begin
                    if (res2 > SMAX) begin
                        res3 <= SMAX[W-1:0];
                        ovf3 <= 1'b1;
                    end else if (res2 < SMIN) begin
                        res3 <= SMIN[W-1:0];
                        ovf3 <= 1'b1;
                    end else begin
                        res3 <= res2[W-1:0];
                        ovf3 <= 1'b0;
                    end
                end
            end
        end
    end
endmodule
